// File: rtl/multdiv_ctrl.sv
// ---------------------------------------------------------------------------
// multdiv_ctrl
//
// Sequences one multiply or divide operation through an external multdiv unit
// and offers the result for writeback.
//
//   IDLE  : accepts an operation (issue_ready=1) and captures opA/opB/is_div/rd
//   START : one-cycle md_ctrl_MULT or md_ctrl_DIV pulse to the unit
//   WAIT  : counts cycles. md_resultRDY is accepted once the counter reaches
//           MIN_LATENCY. At TIMEOUT_CYCLES without a result, an exception
//           writeback is forced.
//   DONE  : wb_valid=1 until wb_ack. An operation with rd=0 has no
//           destination, so it skips DONE and returns straight to IDLE.
//
// Ports
//   clock, resetn                   clock, synchronous active-low reset
//   issue_valid/is_div/opA/opB/rd   operation request
//   issue_ready                     controller accepts a request this cycle
//   md_operandA/B, md_ctrl_MULT/DIV operands and start pulses to the unit
//   md_result/exception/resultRDY   unit response
//   wb_valid/rd/data/exception      writeback offer
//   wb_ack                          writeback consumer takes the offer
//   hazard_rs1/rs2, hazard_stall    decode source tags against the pending rd
//   busy                            controller not in IDLE
// ---------------------------------------------------------------------------
module multdiv_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned MIN_LATENCY    = 2
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        issue_valid,
  input  logic        issue_is_div,
  input  logic [31:0] issue_opA,
  input  logic [31:0] issue_opB,
  input  logic [4:0]  issue_rd,
  output logic        issue_ready,
  output logic [31:0] md_operandA,
  output logic [31:0] md_operandB,
  output logic        md_ctrl_MULT,
  output logic        md_ctrl_DIV,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_resultRDY,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_exception,
  input  logic        wb_ack,
  input  logic [4:0]  hazard_rs1,
  input  logic [4:0]  hazard_rs2,
  output logic        hazard_stall,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [7:0] MIN_LAT = 8'(MIN_LATENCY);
  localparam logic [7:0] TMO     = 8'(TIMEOUT_CYCLES);

  state_t      state;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        is_div;
  logic [4:0]  rd;
  logic [7:0]  cnt;
  logic [31:0] res_data;
  logic        res_exc;

  logic accept;
  logic timeout;
  logic has_rd;

  // Ready is only trusted once the unit's minimum latency has elapsed, so a
  // ready left high from a previous operation cannot be taken as this result.
  assign accept  = (state == S_WAIT) && md_resultRDY && (cnt >= MIN_LAT);
  assign timeout = (state == S_WAIT) && (cnt == TMO);
  assign has_rd  = (rd != 5'd0);

  // NOTE: every state register is assigned with <= so that all of them update
  // from the same pre-edge values. Blocking assignments here would let later
  // lines observe values written earlier in the same edge.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      // NOTE: the reset clears every register here. No register is left to
      // power-up garbage, because a result arriving after a mid-operation
      // reset must find nothing pending.
      state    <= S_IDLE;
      op_a     <= '0;
      op_b     <= '0;
      is_div   <= 1'b0;
      rd       <= '0;
      cnt      <= '0;
      res_data <= '0;
      res_exc  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (issue_valid) begin
            op_a   <= issue_opA;
            op_b   <= issue_opB;
            is_div <= issue_is_div;
            rd     <= issue_rd;
            cnt    <= '0;
            state  <= S_START;
          end
        end
        S_START: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // A result accepted in the same cycle as the timeout takes priority.
          if (accept) begin
            res_data <= md_result;
            res_exc  <= md_exception;
            state    <= has_rd ? S_DONE : S_IDLE;
          end else if (timeout) begin
            res_data <= '0;
            res_exc  <= 1'b1;
            state    <= has_rd ? S_DONE : S_IDLE;
          end else if (cnt != 8'hFF) begin
            cnt <= cnt + 8'd1;
          end
        end
        S_DONE: begin
          if (wb_ack) state <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded from registered state. They are additionally forced to
  // their idle values while resetn is low, so they are correct during reset
  // even before the first reset edge has been taken.
  assign issue_ready  = !resetn || (state == S_IDLE);
  assign busy         = resetn && (state != S_IDLE);
  assign md_ctrl_MULT = resetn && (state == S_START) && !is_div;
  assign md_ctrl_DIV  = resetn && (state == S_START) &&  is_div;
  assign md_operandA  = resetn ? op_a : '0;
  assign md_operandB  = resetn ? op_b : '0;
  assign wb_valid     = resetn && (state == S_DONE);
  assign wb_rd        = rd;
  assign wb_data      = res_data;
  assign wb_exception = res_exc;
  assign hazard_stall = busy && has_rd &&
                        ((hazard_rs1 == rd) || (hazard_rs2 == rd));

endmodule
